// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the memory-mapped I/O UART transmitter.
// Holds FSM encoding, line levels and the I/O register address.
package io_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic        UART_IDLE_LEVEL    = 1'b1;
    localparam int          BYTES_PER_WORD     = 4;
    localparam logic [31:0] MEM_MAP_IO_ADDRESS = 32'd64;

    // Even parity bit: makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/io_uart_tx_baud_gen.sv
// Bit-period down-counter for the UART transmitter.
// Ports: clk, rst (async high), reload_i (restart period), tick_o (period end).
module io_uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (reload_i) begin
            cnt_q <= RELOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Reloading to N-1 and ticking at zero gives exactly N cycles per period.
    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/io_uart_tx.sv
// Serializes each new value of the memory-mapped I/O register as 4 UART bytes.
// Ports: clk, rst (async high), io_val (I/O register), tx (serial line),
// busy (word in flight), overrun (pending value replaced before sending).
// Build option: define IO_UART_TX_PARITY_EN to add an even parity bit per byte.
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] io_val,
    output logic                 tx,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    uart_state_e          state_q;
    logic [BUS_WIDTH-1:0] prev_val_q;
    logic [BUS_WIDTH-1:0] shift_q;
    logic [BUS_WIDTH-1:0] pend_word_q;
    logic                 pending_q;
    logic [2:0]           bit_idx_q;
    logic [1:0]           byte_idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic       tick;
    logic       reload;
    logic       new_val;
    logic       last_stop;
    logic [7:0] cur_byte;
    logic [2:0] nxt_bit;

    assign new_val   = (io_val != prev_val_q);
    assign cur_byte  = shift_q[{byte_idx_q, 3'b000} +: 8];
    assign nxt_bit   = bit_idx_q + 3'd1;
    assign last_stop = (state_q == ST_STOP) && tick && (byte_idx_q == LAST_BYTE);

    // Counter is held at full period while idle, so START lasts a whole bit.
    assign reload = (state_q == ST_IDLE) || tick;

    io_uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .reload_i(reload),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_val_q  <= '0;
            shift_q     <= '0;
            pend_word_q <= '0;
            pending_q   <= 1'b0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            tx_q        <= UART_IDLE_LEVEL;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_val_q <= io_val;
            overrun_q  <= 1'b0;

            // Mid-word arrivals go to the one-deep buffer, newest wins.
            // The final STOP edge handles its own arrival below.
            if (new_val && (state_q != ST_IDLE) && !last_stop) begin
                pend_word_q <= io_val;
                pending_q   <= 1'b1;
                overrun_q   <= pending_q;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (new_val) begin
                        shift_q    <= io_val;
                        byte_idx_q <= '0;
                        state_q    <= ST_START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= even_parity(cur_byte);
`else
                            state_q <= ST_STOP;
                            tx_q    <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx_q <= nxt_bit;
                            tx_q      <= cur_byte[nxt_bit];
                        end
                    end
                end
`ifdef IO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state_q <= ST_STOP;
                        tx_q    <= UART_IDLE_LEVEL;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            state_q    <= ST_START;
                            tx_q       <= 1'b0;
                        end else if (pending_q) begin
                            // Buffered word goes out with no idle gap; a
                            // same-cycle arrival refills the freed slot.
                            shift_q     <= pend_word_q;
                            pending_q   <= new_val;
                            if (new_val) begin
                                pend_word_q <= io_val;
                            end
                            byte_idx_q  <= '0;
                            state_q     <= ST_START;
                            tx_q        <= 1'b0;
                        end else if (new_val) begin
                            shift_q    <= io_val;
                            byte_idx_q <= '0;
                            state_q    <= ST_START;
                            tx_q       <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= UART_IDLE_LEVEL;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= UART_IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
